// File: rtl/cache_controller_2way.sv
// 2-way set-associative, write-back / write-allocate data cache with a 1-bit LRU per set.
// Lines move to and from the word-wide RAM as bursts; hit/miss counters aid profiling.
module cache_controller_2way #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 4,
  parameter int WORD_OFF_W = 2,
  parameter int BYTE_OFF_W = 2,
  parameter int CNT_W      = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_rw,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int LINE_WORDS = 1 << WORD_OFF_W;
  localparam int SETS       = 1 << IDX_W;
  localparam int TAG_W      = ADDR_W - IDX_W - WORD_OFF_W - BYTE_OFF_W;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WRITE_BACK, S_FILL, S_RESPOND} state_e;

  state_e                     state_q, state_d;
  logic [ADDR_W-1:BYTE_OFF_W] addr_q, addr_d;
  logic [DATA_W-1:0]          wdata_q, wdata_d;
  logic                       rw_q, rw_d;
  logic                       first_q, first_d;
  logic                       victim_q, victim_d;
  logic [WORD_OFF_W-1:0]      word_q, word_d;
  logic [DATA_W-1:0]          cpu_rdata_q, cpu_rdata_d;
  logic [CNT_W-1:0]           hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]           miss_cnt_q, miss_cnt_d;
  logic [SETS-1:0]            valid_q [2];
  logic [SETS-1:0]            valid_d [2];
  logic [SETS-1:0]            dirty_q [2];
  logic [SETS-1:0]            dirty_d [2];
  logic [SETS-1:0]            lru_q, lru_d;
  logic [TAG_W-1:0]           tag_q [2][SETS];
  logic [TAG_W-1:0]           tag_d [2][SETS];
  logic [DATA_W-1:0]          data_q [2][SETS][LINE_WORDS];

  logic                  data_we, data_way;
  logic [WORD_OFF_W-1:0] data_word;
  logic [DATA_W-1:0]     data_wval;

  logic unused_byte_off;
  assign unused_byte_off = ^cpu_addr[BYTE_OFF_W-1:0];

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [WORD_OFF_W-1:0] req_word;
  assign req_tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx  = addr_q[BYTE_OFF_W+WORD_OFF_W +: IDX_W];
  assign req_word = addr_q[BYTE_OFF_W +: WORD_OFF_W];

  logic hit0, hit1, hit, hit_way, victim_sel, last_word;
  assign hit0       = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
  assign hit1       = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
  assign hit        = hit0 || hit1;
  assign hit_way    = !hit0;
  assign victim_sel = !valid_q[0][req_idx] ? 1'b0 :
                      !valid_q[1][req_idx] ? 1'b1 : lru_q[req_idx];
  assign last_word  = (word_q == WORD_OFF_W'(LINE_WORDS - 1));

  assign cpu_ready = (state_q == S_IDLE) || (state_q == S_RESPOND);
  assign cpu_done  = (state_q == S_RESPOND);
  assign cpu_rdata = cpu_rdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == S_WRITE_BACK) begin
      mem_write = 1'b1;
      mem_addr  = {tag_q[victim_q][req_idx], req_idx, word_q, {BYTE_OFF_W{1'b0}}};
      mem_wdata = data_q[victim_q][req_idx][word_q];
    end else if (state_q == S_FILL) begin
      mem_read = 1'b1;
      mem_addr = {req_tag, req_idx, word_q, {BYTE_OFF_W{1'b0}}};
    end
  end

  always_comb begin
    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rw_d        = rw_q;
    first_d     = first_q;
    victim_d    = victim_q;
    word_d      = word_q;
    cpu_rdata_d = cpu_rdata_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    lru_d       = lru_q;
    tag_d       = tag_q;
    data_we     = 1'b0;
    data_way    = victim_q;
    data_word   = word_q;
    data_wval   = mem_rdata;
    unique case (state_q)
      S_IDLE, S_RESPOND: begin
        state_d = S_IDLE;
        if (cpu_valid) begin
          addr_d  = cpu_addr[ADDR_W-1:BYTE_OFF_W];
          wdata_d = cpu_wdata;
          rw_d    = cpu_rw;
          first_d = 1'b1;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        first_d = 1'b0;
        if (hit) begin
          if (first_q) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          if (rw_q) begin
            data_we   = 1'b1;
            data_way  = hit_way;
            data_word = req_word;
            data_wval = wdata_q;
            dirty_d[hit_way][req_idx] = 1'b1;
          end else begin
            cpu_rdata_d = data_q[hit_way][req_idx][req_word];
          end
          lru_d[req_idx] = ~hit_way;
          state_d = S_RESPOND;
        end else begin
          if (first_q) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          victim_d = victim_sel;
          word_d   = '0;
          state_d  = (valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx])
                     ? S_WRITE_BACK : S_FILL;
        end
      end
      S_WRITE_BACK: begin
        if (mem_ready) begin
          word_d = word_q + WORD_OFF_W'(1);
          if (last_word) state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (mem_ready) begin
          data_we = 1'b1;
          word_d  = word_q + WORD_OFF_W'(1);
          if (last_word) begin
            tag_d[victim_q][req_idx]   = req_tag;
            valid_d[victim_q][req_idx] = 1'b1;
            dirty_d[victim_q][req_idx] = 1'b0;
            state_d = S_LOOKUP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rw_q        <= 1'b0;
      first_q     <= 1'b0;
      victim_q    <= 1'b0;
      word_q      <= '0;
      cpu_rdata_q <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      valid_q     <= '{default: '0};
      dirty_q     <= '{default: '0};
      lru_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rw_q        <= rw_d;
      first_q     <= first_d;
      victim_q    <= victim_d;
      word_q      <= word_d;
      cpu_rdata_q <= cpu_rdata_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      lru_q       <= lru_d;
    end
  end

  // NOTE: tags and line data are left unreset; valid_q qualifies every use of them.
  always_ff @(posedge iCLK) begin
    tag_q <= tag_d;
    if (data_we) data_q[data_way][req_idx][data_word] <= data_wval;
  end

endmodule
